// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and byte-lane constants for the instruction loader (LOADER_CHECKSUM_EN adds CHECK)
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BYTE0,
    S_BYTE1,
    S_BYTE2,
    S_WRITE,
    S_DONE
`ifdef LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  localparam int BYTES_PER_INSTR = 3;
  localparam int LANE_W = $clog2(BYTES_PER_INSTR);

  // Bits of the third byte that do not reach the instruction word.
  localparam logic [7:0] BYTE2_UNUSED_MASK = 8'hF8;

endpackage

// File: rtl/instruction_assembler.sv
// rtl/instruction_assembler.sv - little-endian byte-lane capture register that builds one instruction word
module instruction_assembler
  import loader_pkg::*;
#(
  parameter int INSTR_LEN = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 capture,
  input  logic [LANE_W-1:0]    lane,
  input  logic [7:0]           byte_in,
  output logic [INSTR_LEN-1:0] word
);

  logic [7:0] high_byte;
  logic       unused_high;

  assign high_byte   = byte_in & ~BYTE2_UNUSED_MASK;
  assign unused_high = ^high_byte[7:INSTR_LEN-16];

  // Drop each accepted byte into its lane; the top lane keeps only the low bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
    end else if (capture) begin
      if (lane == LANE_W'(0)) begin
        word[7:0] <= byte_in;
      end else if (lane == LANE_W'(1)) begin
        word[15:8] <= byte_in;
      end else begin
        word[INSTR_LEN-1:16] <= high_byte[INSTR_LEN-17:0];
      end
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - streams bytes into instruction memory while holding the CPU in reset (LOADER_CHECKSUM_EN adds XOR check)
module instruction_loader
  import loader_pkg::*;
#(
  parameter int INSTR_LEN = 19,
  parameter int ADDR_LEN  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_LEN-1:0]  prog_len,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 im_write_en,
  output logic [ADDR_LEN-1:0]  im_write_addr,
  output logic [INSTR_LEN-1:0] im_write_data,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FINISH = S_CHECK;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  state_t              state, next_state;
  logic [ADDR_LEN-1:0] len_q, addr_q, count_q, count_next;
  logic                accept_start, handshake, last_instr, capture;
  logic [LANE_W-1:0]   lane;

  assign accept_start = start && (state == S_IDLE || state == S_DONE);
  assign handshake    = in_valid && in_ready;
  assign count_next   = count_q + ADDR_LEN'(1);
  assign last_instr   = (count_next == len_q);
  assign capture      = handshake && (state == S_BYTE0 || state == S_BYTE1 || state == S_BYTE2);
  assign lane         = (state == S_BYTE0) ? LANE_W'(0) :
                        (state == S_BYTE1) ? LANE_W'(1) : LANE_W'(2);

  assign im_write_addr = addr_q;

  instruction_assembler #(.INSTR_LEN(INSTR_LEN)) u_assembler (
    .clk     (clk),
    .rst     (rst),
    .capture (capture),
    .lane    (lane),
    .byte_in (in_data),
    .word    (im_write_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Length capture plus address and instruction counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      addr_q  <= '0;
      count_q <= '0;
    end else if (accept_start) begin
      len_q   <= prog_len;
      addr_q  <= '0;
      count_q <= '0;
    end else if (state == S_WRITE) begin
      addr_q  <= addr_q + ADDR_LEN'(1);
      count_q <= count_next;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  logic       error_q;

  assign error = error_q;

  // Running XOR of data bytes, and the sticky error flag cleared by the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q  <= '0;
      error_q <= 1'b0;
    end else if (accept_start) begin
      csum_q  <= '0;
      error_q <= 1'b0;
    end else if (capture) begin
      csum_q  <= csum_q ^ in_data;
    end else if (state == S_CHECK && handshake && in_data != csum_q) begin
      error_q <= 1'b1;
    end
  end
`else
  assign error = 1'b0;
`endif

  // Next-state and Moore outputs.
  always_comb begin
    next_state  = state;
    in_ready    = 1'b0;
    im_write_en = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    cpu_rst     = 1'b1;
    case (state)
      S_IDLE, S_DONE: begin
        if (state == S_DONE) begin
          done    = 1'b1;
          cpu_rst = 1'b0;
        end
        if (accept_start) next_state = (prog_len == '0) ? S_FINISH : S_BYTE0;
      end
      S_BYTE0: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (handshake) next_state = S_BYTE1;
      end
      S_BYTE1: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (handshake) next_state = S_BYTE2;
      end
      S_BYTE2: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (handshake) next_state = S_WRITE;
      end
      S_WRITE: begin
        im_write_en = 1'b1;
        busy        = 1'b1;
        next_state  = last_instr ? S_FINISH : S_BYTE0;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (handshake) next_state = (in_data == csum_q) ? S_DONE : S_IDLE;
      end
`endif
      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter INSTR_LEN, default 19, instruction word width in bits; matches the instruction memory word.
REQ-002 Parameter ADDR_LEN, default 12, instruction memory address width in bits.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous and active-high.
REQ-005 Port start, input, 1, single-cycle request to begin a load.
REQ-006 Port prog_len, input, ADDR_LEN, number of instructions to load; sampled when start is accepted.
REQ-007 Port in_valid, input, 1, a byte is present on in_data.
REQ-008 Port in_data, input, 8, byte stream payload.
REQ-009 Port in_ready, output, 1, loader accepts in_data this cycle.
REQ-010 Port im_write_en, output, 1, instruction memory write strobe.
REQ-011 Port im_write_addr, output, ADDR_LEN, instruction memory write address.
REQ-012 Port im_write_data, output, INSTR_LEN, assembled instruction.
REQ-013 Port cpu_rst, output, 1, holds the processor pipeline in reset.
REQ-014 Port busy, output, 1, a load is in progress.
REQ-015 Port done, output, 1, last load completed successfully.
REQ-016 Port error, output, 1, last load failed its checksum.

Function
REQ-017 States: IDLE, BYTE0, BYTE1, BYTE2, WRITE, DONE, plus CHECK when the REQ-032 macro is defined.
REQ-018 Byte handshake: a byte transfers in a cycle where in_valid and in_ready are both 1; in_ready is 1 only in BYTE0, BYTE1, BYTE2 and CHECK.
REQ-019 Start: start is accepted only in IDLE or DONE. On acceptance: capture prog_len, clear the address and instruction counters to 0, clear done and error, then go to BYTE0.
REQ-020 Start with prog_len = 0: go directly to DONE (or to CHECK when checksum is enabled) with no memory write.
REQ-021 Start while in any other state: ignored.
REQ-022 Byte order is little-endian: BYTE0 supplies bits [7:0], BYTE1 supplies [15:8], BYTE2 bits [2:0] supply [18:16]. BYTE2 bits [7:3] are discarded.
REQ-023 Each BYTE state advances only on a handshake; with in_valid low it holds indefinitely.
REQ-024 After the BYTE2 handshake the loader enters WRITE for exactly one cycle: im_write_en = 1, current address and assembled word driven, in_ready = 0.
REQ-025 On leaving WRITE: address and count increment. If count+1 equals prog_len, go to DONE (or CHECK); otherwise go to BYTE0.
REQ-026 Address arithmetic is modulo 2^ADDR_LEN; 4095 wraps to 0 without an error.
REQ-027 Latency: the write strobe is asserted one cycle after the BYTE2 handshake. Minimum throughput is 4 cycles per instruction.
REQ-028 cpu_rst = 1 in every state except DONE; busy = 1 in BYTE0..CHECK.
REQ-029 done = 1 in DONE and 0 otherwise. error holds its value until the next accepted start.
REQ-030 im_write_addr and im_write_data are don't-care when im_write_en = 0; im_write_en is never high outside WRITE.

Reset
REQ-031 When rst is asserted, the loader goes to IDLE asynchronously and registers clear:
- state IDLE
- counters, address and checksum 0
- outputs: in_ready = 0, im_write_en = 0, busy = 0, done = 0, error = 0, cpu_rst = 1
- a load interrupted by reset is abandoned; no partial write occurs.

Configuration
REQ-032 Macro LOADER_CHECKSUM_EN defined:
- a running 8-bit XOR of every accepted data byte is kept.
- after the last WRITE, CHECK accepts one byte.
- a match goes to DONE.
- a mismatch sets error = 1 and goes to IDLE with cpu_rst held at 1.
REQ-033 Macro LOADER_CHECKSUM_EN undefined: CHECK state and checksum register are absent, and error is tied to 0.

Structure
REQ-034 Shared package loader_pkg holds the state enum typedef, the byte-per-instruction constant (3), and the unused-bit mask for BYTE2.
REQ-035 One sub-module, instruction_assembler, holds the byte-lane shift/capture register that produces im_write_data.

Verification
REQ-036 After reset: cpu_rst = 1, in_ready = 0, done = 0; no im_write_en for 20 cycles with in_valid = 1.
REQ-037 start with prog_len = 2, then bytes 0x34, 0x12, 0x05, 0xCD, 0xAB, 0xFA:
- write addr 0, data 0x51234
- write addr 1, data 0x2ABCD
- then done = 1, cpu_rst = 0.
REQ-038 in_valid toggled on alternate cycles during a 1-instruction load: the word is written exactly once and no byte is lost or duplicated.
REQ-039 start pulsed mid-load: ignored, and the address sequence is unchanged. start with prog_len = 0: DONE next cycle, zero writes.
REQ-040 rst asserted between BYTE1 and BYTE2: state returns to IDLE immediately, there is no write, and cpu_rst = 1.
REQ-041 LOADER_CHECKSUM_EN, bytes 0x01, 0x02, 0x03:
- checksum byte 0x00 gives done = 1.
- checksum byte 0xFF gives error = 1, state IDLE, cpu_rst = 1.
